lzrw1_stream_unpacker: RTL
==========================

Name: lzrw1_stream_unpacker

Overview:
- Sits directly upstream of decompressor_top.
- Takes a single interleaved LZRW1 compressed byte stream: one control byte, then up to 8 items.
- Splits the stream into items and presents each item, with its flag, on the decompressor's data_in / control_word_in / data_in_valid interface, throttled by decompressor_busy.
- Replaces the separate compressed/control-word files as the decompressor's front end.

Parameters:
ITEM_COUNT_WIDTH, 16, width of item_count status counter (saturating).

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
in_byte  input  8  compressed stream byte.
in_valid  input  1  in_byte valid.
in_last  input  1  in_byte is final byte of stream; qualified by in_valid.
in_ready  output  1  unpacker accepts in_byte this cycle.
data_in  output  16  item to decompressor: copy = {byte0,byte1}; literal = {8'h00,byte0}.
control_word_in  output  1  item flag: 1 = copy, 0 = literal.
data_in_valid  output  1  item valid to decompressor.
decompressor_busy  input  1  decompressor ignoring inputs when 1.
stream_done  output  1  one-cycle pulse: stream fully processed.
trunc_error  output  1  sticky: stream ended inside a copy item; cleared by reset or next accepted control byte.
item_count  output  ITEM_COUNT_WIDTH  items delivered since the last control byte following stream_done; saturates at all-ones.

Behaviour:
- Reset (reset=0, async): state CTRL, flag_idx=0, ctrl_reg=0.
  - Outputs at reset: in_ready=0, data_in=0, control_word_in=0, data_in_valid=0, stream_done=0, trunc_error=0, item_count=0.
  - in_ready goes to 1 on the first clock after reset release.
- Byte accept: in_valid && in_ready at rising edge.
  - in_ready is registered and is 1 only in states CTRL, ITEM_LO and ITEM_HI.
  - No combinational path from decompressor_busy to in_ready.
- States:
  - CTRL: on accept, ctrl_reg<=in_byte, flag_idx<=0, clear trunc_error.
    - in_last=1 -> DONE.
    - Otherwise -> ITEM_LO.
  - ITEM_LO: on accept, byte0<=in_byte.
    - Flag is ctrl_reg[7-flag_idx]; MSB is consumed first.
    - Flag=0 -> PRESENT.
    - Flag=1 and in_last=0 -> ITEM_HI.
    - Flag=1 and in_last=1 -> set trunc_error, drop item, -> DONE.
  - ITEM_HI: on accept, byte1<=in_byte -> PRESENT.
  - PRESENT: data_in_valid=1 with data_in/control_word_in held stable.
    - Transfer occurs at the rising edge where data_in_valid=1 and decompressor_busy=0.
    - On transfer: item_count++, flag_idx++, -> GAP.
    - While busy=1, hold indefinitely.
  - GAP: data_in_valid=0 for exactly one cycle, so the decompressor can raise busy.
    - If the item's byte carried in_last -> DONE.
    - Else if flag_idx==8 -> CTRL.
    - Else -> ITEM_LO.
  - DONE: stream_done=1 for one cycle -> CTRL.
    - item_count holds until the next control byte is accepted, then resets to 0.
- data_in_valid is never high for two items without an intervening GAP cycle; one transfer per item exactly.
- data_in and control_word_in keep their last values outside PRESENT.
- Latency (decompressor idle):
  - Literal byte accepted at edge N: data_in_valid=1 after edge N; transfer at edge N+1.
  - Copy second byte accepted at edge N: same timing.
- in_last on a literal or on a copy's second byte: item still delivered, then DONE.
- Remaining flags of the current control byte are discarded on in_last.
- in_valid while in_ready=0: byte is not consumed; source must hold it (valid/ready rule). in_byte must be stable while in_valid=1 and not accepted.
- Reset mid-item: in-flight item lost, no transfer completes, all outputs return to reset values immediately.

Test Plan:
- Control 8'h00, then literals "ABCDEFGH", then control 8'h00 and "I" with in_last, busy=0:
  - 9 transfers, data_in=16'h0041..16'h0049, control_word_in=0.
  - stream_done after the 9th; item_count=9.
- Control 8'h80, copy bytes 8'h12,8'h34, literal 8'h5A with in_last:
  - Transfer 1: data_in=16'h1234, control_word_in=1.
  - Transfer 2: data_in=16'h005A, control_word_in=0.
  - Then stream_done.
- Busy back-pressure: hold decompressor_busy=1 for 5 cycles during PRESENT:
  - data_in_valid stays 1 and data_in stable.
  - Transfer on the first busy=0 edge; one GAP cycle follows.
  - in_ready=0 throughout.
- Truncation: control 8'h40, literal 8'h41, copy first byte 8'h10 with in_last:
  - One transfer (16'h0041); trunc_error=1; stream_done pulse.
  - A new control byte clears trunc_error.
- Control byte with in_last: no data_in_valid, stream_done pulse one cycle later, item_count=0.
- Assert reset during PRESENT with busy=1:
  - data_in_valid=0 immediately, item_count=0.
  - After release, a new stream decodes correctly from its control byte.

Source files
------------

// File: rtl/lzrw1_stream_unpacker.sv
// Front end for decompressor_top: splits an interleaved LZRW1 stream (control byte + up to 8 items)
// into flagged items and hands them over one at a time, throttled by decompressor_busy.
module lzrw1_stream_unpacker #(
  parameter int ITEM_COUNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  in_byte,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [15:0]                 data_in,
  output logic                        control_word_in,
  output logic                        data_in_valid,
  input  logic                        decompressor_busy,
  output logic                        stream_done,
  output logic                        trunc_error,
  output logic [ITEM_COUNT_WIDTH-1:0] item_count
);

  typedef enum logic [2:0] {
    S_CTRL    = 3'd0,
    S_ITEM_LO = 3'd1,
    S_ITEM_HI = 3'd2,
    S_PRESENT = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  ctrl_q, ctrl_d;
  logic [3:0]                  flag_idx_q, flag_idx_d;
  logic [7:0]                  byte0_q, byte0_d;
  logic                        last_q, last_d;
  logic                        done_seen_q, done_seen_d;
  logic                        in_ready_q;
  logic [15:0]                 data_q, data_d;
  logic                        cw_q, cw_d;
  logic                        valid_q;
  logic                        done_q;
  logic                        trunc_q, trunc_d;
  logic [ITEM_COUNT_WIDTH-1:0] count_q, count_d;
  logic                        accept_s;
  logic [2:0]                  flag_pos_s;
  logic                        flag_s;

  assign accept_s   = in_valid && in_ready_q;
  assign flag_pos_s = 3'd7 - flag_idx_q[2:0];
  assign flag_s     = ctrl_q[flag_pos_s];

  // Next-state and datapath updates for the item splitter
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    flag_idx_d  = flag_idx_q;
    byte0_d     = byte0_q;
    last_d      = last_q;
    done_seen_d = done_seen_q;
    data_d      = data_q;
    cw_d        = cw_q;
    trunc_d     = trunc_q;
    count_d     = count_q;
    case (state_q)
      S_CTRL: begin
        if (accept_s) begin
          ctrl_d     = in_byte;
          flag_idx_d = 4'd0;
          trunc_d    = 1'b0;
          // The count survives intermediate control bytes; only a new stream restarts it.
          if (done_seen_q) begin
            count_d     = {ITEM_COUNT_WIDTH{1'b0}};
            done_seen_d = 1'b0;
          end else begin
            count_d = count_q;
          end
          state_d = in_last ? S_DONE : S_ITEM_LO;
        end else begin
          state_d = S_CTRL;
        end
      end
      S_ITEM_LO: begin
        if (accept_s) begin
          byte0_d = in_byte;
          if (!flag_s) begin
            data_d  = {8'h00, in_byte};
            cw_d    = 1'b0;
            last_d  = in_last;
            state_d = S_PRESENT;
          end else if (in_last) begin
            trunc_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ITEM_HI;
          end
        end else begin
          state_d = S_ITEM_LO;
        end
      end
      S_ITEM_HI: begin
        if (accept_s) begin
          data_d  = {byte0_q, in_byte};
          cw_d    = 1'b1;
          last_d  = in_last;
          state_d = S_PRESENT;
        end else begin
          state_d = S_ITEM_HI;
        end
      end
      S_PRESENT: begin
        if (!decompressor_busy) begin
          if (count_q != {ITEM_COUNT_WIDTH{1'b1}}) begin
            count_d = count_q + {{(ITEM_COUNT_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            count_d = count_q;
          end
          flag_idx_d = flag_idx_q + 4'd1;
          state_d    = S_GAP;
        end else begin
          state_d = S_PRESENT;
        end
      end
      S_GAP: begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (flag_idx_q == 4'd8) begin
          state_d = S_CTRL;
        end else begin
          state_d = S_ITEM_LO;
        end
      end
      S_DONE: begin
        done_seen_d = 1'b1;
        state_d     = S_CTRL;
      end
      default: begin
        state_d = S_CTRL;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CTRL;
      ctrl_q      <= 8'h00;
      flag_idx_q  <= 4'd0;
      byte0_q     <= 8'h00;
      last_q      <= 1'b0;
      done_seen_q <= 1'b0;
      in_ready_q  <= 1'b0;
      data_q      <= 16'h0000;
      cw_q        <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
      count_q     <= {ITEM_COUNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      flag_idx_q  <= flag_idx_d;
      byte0_q     <= byte0_d;
      last_q      <= last_d;
      done_seen_q <= done_seen_d;
      in_ready_q  <= (state_d == S_CTRL) || (state_d == S_ITEM_LO) || (state_d == S_ITEM_HI);
      data_q      <= data_d;
      cw_q        <= cw_d;
      valid_q     <= (state_d == S_PRESENT);
      done_q      <= (state_d == S_DONE);
      trunc_q     <= trunc_d;
      count_q     <= count_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign data_in         = data_q;
  assign control_word_in = cw_q;
  assign data_in_valid   = valid_q;
  assign stream_done     = done_q;
  assign trunc_error     = trunc_q;
  assign item_count      = count_q;

endmodule
